// File: rtl/rv_check_monitor.sv
// rv_check_monitor: retire-stream checker with expected-value table and shadows.
// Optional halt output built when RV_CHECK_HALT_EN is defined.
module rv_check_monitor #(
  parameter int DEPTH  = 128,
  parameter int CHECKS = 3,
  parameter int XLEN   = 32,
  parameter int CNT_W  = 16,
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int SW = (CHECKS > 1) ? $clog2(CHECKS) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [IW-1:0]   cfg_index,
  input  logic [SW-1:0]   cfg_slot,
  input  logic [5:0]      cfg_target,
  input  logic [XLEN-1:0] cfg_value,
  input  logic            cfg_clear,
  input  logic            ret_valid,
  input  logic [XLEN-1:0] ret_pc,
  input  logic [XLEN-1:0] ret_next_pc,
  input  logic            ret_rd_we,
  input  logic [4:0]      ret_rd,
  input  logic [XLEN-1:0] ret_rd_data,
  input  logic            ret_mem_we,
  input  logic [5:0]      ret_mem_idx,
  input  logic [XLEN-1:0] ret_mem_data,
  output logic            chk_valid,
  output logic [CHECKS-1:0] chk_fail,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic            first_fail_valid,
  output logic [XLEN-1:0] first_fail_pc,
  output logic [5:0]      first_fail_target,
  output logic [XLEN-1:0] first_fail_expected,
  output logic [XLEN-1:0] first_fail_actual,
  output logic            halt
);

  localparam logic [5:0] T_EMPTY = 6'd63;
  localparam logic [5:0] T_NPC   = 6'd32;
  localparam logic [5:0] M_LO    = 6'd33;
  localparam logic [5:0] M_HI    = 6'd62;

  logic          sweep_q;
  logic [IW-1:0] sweep_idx_q;

  logic [5:0]      tbl_tgt [DEPTH][CHECKS];
  logic [XLEN-1:0] tbl_val [DEPTH][CHECKS];
  logic [5:0]      rd_tgt_q [CHECKS];
  logic [XLEN-1:0] rd_val_q [CHECKS];

  logic [XLEN-1:0] sreg_q [32];
  logic [XLEN-1:0] smem_q [64];

  logic            s1_chk_q;
  logic [XLEN-1:0] s1_pc_q;
  logic [XLEN-1:0] s1_npc_q;

  logic            cfg_fire;
  logic            cfg_ok;
  logic [IW-1:0]   ret_idx;
  logic [XLEN-3:0] ret_word;
  logic            ret_ok;

  logic [XLEN-1:0]   act [CHECKS];
  logic [CHECKS-1:0] fail_d;
  logic              any_d;
  logic              ff_hit_d;
  logic [5:0]        ff_tgt_d;
  logic [XLEN-1:0]   ff_exp_d;
  logic [XLEN-1:0]   ff_act_d;
  logic              chk_fire;

  logic              chk_valid_q;
  logic [CHECKS-1:0] chk_fail_q;
  logic [CNT_W-1:0]  pass_q;
  logic [CNT_W-1:0]  fail_q;
  logic              ff_valid_q;
  logic [XLEN-1:0]   ff_pc_q;
  logic [5:0]        ff_tgt_q;
  logic [XLEN-1:0]   ff_exp_q;
  logic [XLEN-1:0]   ff_act_q;

  assign cfg_ready = ~sweep_q;
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign cfg_ok    = (int'(cfg_slot) < CHECKS) && (int'(cfg_index) < DEPTH);
  assign ret_idx   = ret_pc[IW+1:2];
  assign ret_word  = ret_pc[XLEN-1:2];
  assign ret_ok    = (ret_pc[1:0] == 2'b00) &&
                     (ret_word < (XLEN-2)'(DEPTH)) &&
                     !sweep_q && !cfg_clear;

  // Clear sweep: one entry per cycle, restarted by cfg_clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sweep_q     <= 1'b1;
      sweep_idx_q <= '0;
    end else if (cfg_clear) begin
      sweep_q     <= 1'b1;
      sweep_idx_q <= '0;
    end else if (sweep_q) begin
      sweep_idx_q <= sweep_idx_q + 1'b1;
      if (sweep_idx_q == IW'(DEPTH - 1))
        sweep_q <= 1'b0;
    end
  end

  // Table storage: sweep/config writes, synchronous entry read (old data on collision)
  always_ff @(posedge clock) begin
    if (sweep_q) begin
      for (int s = 0; s < CHECKS; s++)
        tbl_tgt[sweep_idx_q][s] <= T_EMPTY;
    end else if (cfg_fire && cfg_ok) begin
      tbl_tgt[cfg_index][cfg_slot] <= cfg_target;
      tbl_val[cfg_index][cfg_slot] <= cfg_value;
    end
    if (ret_valid) begin
      for (int s = 0; s < CHECKS; s++) begin
        rd_tgt_q[s] <= tbl_tgt[ret_idx][s];
        rd_val_q[s] <= tbl_val[ret_idx][s];
      end
    end
  end

  // Shadow register file and data-memory window, updated at end of retire cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 32; r++) sreg_q[r] <= '0;
      for (int m = 0; m < 64; m++) smem_q[m] <= '0;
    end else if (ret_valid) begin
      if (ret_rd_we && ret_rd != 5'd0)
        sreg_q[ret_rd] <= ret_rd_data;
      if (ret_mem_we && ret_mem_idx >= M_LO && ret_mem_idx <= M_HI)
        smem_q[ret_mem_idx] <= ret_mem_data;
    end
  end

  // Stage 1: register the retire event
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_chk_q <= 1'b0;
      s1_pc_q  <= '0;
      s1_npc_q <= '0;
    end else begin
      s1_chk_q <= ret_valid & ret_ok;
      if (ret_valid) begin
        s1_pc_q  <= ret_pc;
        s1_npc_q <= ret_next_pc;
      end
    end
  end

  // Stage 2: compare each non-empty slot, pick the lowest failing slot
  always_comb begin
    fail_d   = '0;
    any_d    = 1'b0;
    ff_hit_d = 1'b0;
    ff_tgt_d = '0;
    ff_exp_d = '0;
    ff_act_d = '0;
    for (int s = 0; s < CHECKS; s++) begin
      act[s] = '0;
      if (rd_tgt_q[s] < T_NPC)
        act[s] = sreg_q[rd_tgt_q[s][4:0]];
      else if (rd_tgt_q[s] == T_NPC)
        act[s] = s1_npc_q;
      else
        act[s] = smem_q[rd_tgt_q[s]];
      if (rd_tgt_q[s] != T_EMPTY) begin
        any_d = 1'b1;
        if (act[s] != rd_val_q[s]) begin
          fail_d[s] = 1'b1;
          if (!ff_hit_d) begin
            ff_hit_d = 1'b1;
            ff_tgt_d = rd_tgt_q[s];
            ff_exp_d = rd_val_q[s];
            ff_act_d = act[s];
          end
        end
      end
    end
  end

  assign chk_fire = s1_chk_q & any_d;

  // Result registers, saturating counters and sticky first-failure capture
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      chk_valid_q <= 1'b0;
      chk_fail_q  <= '0;
      pass_q      <= '0;
      fail_q      <= '0;
      ff_valid_q  <= 1'b0;
      ff_pc_q     <= '0;
      ff_tgt_q    <= '0;
      ff_exp_q    <= '0;
      ff_act_q    <= '0;
    end else begin
      chk_valid_q <= chk_fire;
      if (chk_fire) begin
        chk_fail_q <= fail_d;
        if (fail_d == '0) begin
          if (pass_q != '1) pass_q <= pass_q + 1'b1;
        end else begin
          if (fail_q != '1) fail_q <= fail_q + 1'b1;
        end
      end
      if (chk_fire && ff_hit_d && !ff_valid_q) begin
        ff_valid_q <= 1'b1;
        ff_pc_q    <= s1_pc_q;
        ff_tgt_q   <= ff_tgt_d;
        ff_exp_q   <= ff_exp_d;
        ff_act_q   <= ff_act_d;
      end
    end
  end

  assign chk_valid           = chk_valid_q;
  assign chk_fail            = chk_fail_q;
  assign pass_count          = pass_q;
  assign fail_count          = fail_q;
  assign first_fail_valid    = ff_valid_q;
  assign first_fail_pc       = ff_pc_q;
  assign first_fail_target   = ff_tgt_q;
  assign first_fail_expected = ff_exp_q;
  assign first_fail_actual   = ff_act_q;

`ifdef RV_CHECK_HALT_EN
  logic halt_q;

  // Sticky halt, raised the cycle after the first failing check
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      halt_q <= 1'b0;
    else if (chk_valid_q && chk_fail_q != '0)
      halt_q <= 1'b1;
  end

  assign halt = halt_q;
`else
  assign halt = 1'b0;
`endif

endmodule

// File: tb/tb_rv_check_monitor.sv
// tb_rv_check_monitor: directed stimulus with a queue-based scoreboard.
// Counter width reduced to 8 so saturation is reachable quickly.
module tb_rv_check_monitor;
  localparam int DEPTH  = 128;
  localparam int CHECKS = 3;
  localparam int XLEN   = 32;
  localparam int CNT_W  = 8;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clock = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [6:0]        cfg_index = '0;
  logic [1:0]        cfg_slot = '0;
  logic [5:0]        cfg_target = '0;
  logic [XLEN-1:0]   cfg_value = '0;
  logic              cfg_clear = 1'b0;
  logic              ret_valid = 1'b0;
  logic [XLEN-1:0]   ret_pc = '0;
  logic [XLEN-1:0]   ret_next_pc = '0;
  logic              ret_rd_we = 1'b0;
  logic [4:0]        ret_rd = '0;
  logic [XLEN-1:0]   ret_rd_data = '0;
  logic              ret_mem_we = 1'b0;
  logic [5:0]        ret_mem_idx = '0;
  logic [XLEN-1:0]   ret_mem_data = '0;
  logic              chk_valid;
  logic [CHECKS-1:0] chk_fail;
  logic [CNT_W-1:0]  pass_count;
  logic [CNT_W-1:0]  fail_count;
  logic              first_fail_valid;
  logic [XLEN-1:0]   first_fail_pc;
  logic [5:0]        first_fail_target;
  logic [XLEN-1:0]   first_fail_expected;
  logic [XLEN-1:0]   first_fail_actual;
  logic              halt;

  rv_check_monitor #(
    .DEPTH(DEPTH), .CHECKS(CHECKS), .XLEN(XLEN), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_index(cfg_index), .cfg_slot(cfg_slot),
    .cfg_target(cfg_target), .cfg_value(cfg_value),
    .cfg_clear(cfg_clear),
    .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_next_pc(ret_next_pc),
    .ret_rd_we(ret_rd_we), .ret_rd(ret_rd), .ret_rd_data(ret_rd_data),
    .ret_mem_we(ret_mem_we), .ret_mem_idx(ret_mem_idx),
    .ret_mem_data(ret_mem_data),
    .chk_valid(chk_valid), .chk_fail(chk_fail),
    .pass_count(pass_count), .fail_count(fail_count),
    .first_fail_valid(first_fail_valid), .first_fail_pc(first_fail_pc),
    .first_fail_target(first_fail_target),
    .first_fail_expected(first_fail_expected),
    .first_fail_actual(first_fail_actual),
    .halt(halt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [CHECKS-1:0] fail;
    int                pc;
    int                fc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   chk_cyc[$];
  int   m_pass = 0;
  int   m_fail = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_chk(input logic [CHECKS-1:0] mask);
    exp_t e;
    if (mask == '0) begin
      if (m_pass < CMAX) m_pass++;
    end else begin
      if (m_fail < CMAX) m_fail++;
    end
    e.fail = mask;
    e.pc   = m_pass;
    e.fc   = m_fail;
    sb.push_back(e);
  endtask

  task automatic cfg_write(input int idx, input int slot,
                           input int tgt, input logic [XLEN-1:0] val);
    check("cfg_ready_on_write", cfg_ready, 1);
    cfg_valid  = 1'b1;
    cfg_index  = 7'(idx);
    cfg_slot   = 2'(slot);
    cfg_target = 6'(tgt);
    cfg_value  = val;
    @(posedge clock); #1;
    cfg_valid  = 1'b0;
  endtask

  task automatic retire(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] npc,
                        input logic rwe, input int rd, input logic [XLEN-1:0] rdat,
                        input logic mwe, input int midx, input logic [XLEN-1:0] mdat);
    ret_valid    = 1'b1;
    ret_pc       = pc;
    ret_next_pc  = npc;
    ret_rd_we    = rwe;
    ret_rd       = 5'(rd);
    ret_rd_data  = rdat;
    ret_mem_we   = mwe;
    ret_mem_idx  = 6'(midx);
    ret_mem_data = mdat;
    @(posedge clock); #1;
    ret_valid    = 1'b0;
    ret_rd_we    = 1'b0;
    ret_mem_we   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  always @(posedge clock) cyc++;

  // Monitor: pop and compare whenever the DUT presents a check result
  always @(negedge clock) begin
    if (chk_valid) begin
      chk_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_chk: chk_valid=1 mask=0x%0h, required no check",
                 chk_fail);
      end else begin
        mon_e = sb.pop_front();
        check("chk_fail", chk_fail, mon_e.fail);
        check("pass_count", pass_count, mon_e.pc);
        check("fail_count", fail_count, mon_e.fc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic bad;

    #12;
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_chk_valid", chk_valid, 0);
    check("rst_counts", {pass_count, fail_count}, 0);
    check("rst_ff_valid", first_fail_valid, 0);
    check("rst_halt", halt, 0);
    @(negedge clock);
    rst_n = 1'b1;

    n = 0;
    bad = 1'b0;
    while (!cfg_ready && n < 1000) begin
      @(posedge clock); #1;
      n++;
      if (!cfg_ready)
        bad |= chk_valid | (|chk_fail) | (|pass_count) | (|fail_count) |
               first_fail_valid | halt;
    end
    check("sweep_cycles", n, DEPTH);
    check("outputs_zero_in_sweep", bad, 0);

    cfg_write(1, 0, 5, 32'd7);
    expect_chk(3'b000);
    retire(32'h4, 32'h8, 1, 5, 32'd7, 0, 0, 0);
    check("latency_edge1", chk_valid, 0);
    @(posedge clock); #1;
    check("latency_edge2", chk_valid, 1);
    idle(3);
    check("pass_after_first", pass_count, 1);

    cfg_write(2, 0, 32, 32'h20);
    cfg_write(2, 1, 40, 32'hAB);
    expect_chk(3'b001);
    retire(32'h8, 32'h10, 0, 0, 0, 1, 40, 32'hAB);
    idle(3);
    check("ff_valid", first_fail_valid, 1);
    check("ff_pc", first_fail_pc, 32'h8);
    check("ff_target", first_fail_target, 32);
    check("ff_expected", first_fail_expected, 32'h20);
    check("ff_actual", first_fail_actual, 32'h10);
`ifdef RV_CHECK_HALT_EN
    check("halt_set", halt, 1);
`else
    check("halt_tied", halt, 0);
`endif

    for (int k = 0; k < 4; k++) cfg_write(3 + k, 0, 3, k + 1);
    for (int k = 0; k < 4; k++) expect_chk(3'b000);
    chk_cyc.delete();
    for (int k = 0; k < 4; k++)
      retire(32'(12 + 4 * k), 32'(16 + 4 * k), 1, 3, 32'(k + 1), 0, 0, 0);
    idle(4);
    check("b2b_count", chk_cyc.size(), 4);
    for (int k = 1; k < 4 && k < chk_cyc.size(); k++)
      check("b2b_gap", chk_cyc[k] - chk_cyc[k-1], 1);

    retire(32'h1000, 32'h1004, 0, 0, 0, 0, 0, 0);
    retire(32'h1004, 32'h1008, 0, 0, 0, 0, 0, 0);
    retire(32'h6, 32'ha, 0, 0, 0, 0, 0, 0);
    idle(4);
    check("unchecked_pass", pass_count, m_pass);
    check("unchecked_fail", fail_count, m_fail);

    cfg_write(7, 0, 0, 32'd0);
    expect_chk(3'b000);
    retire(32'd28, 32'd32, 1, 0, 32'd5, 0, 0, 0);
    idle(3);

    cfg_write(127, 0, 5, 32'd7);
    cfg_clear = 1'b1;
    @(posedge clock); #1;
    cfg_clear = 1'b0;
    retire(32'h4, 32'h8, 0, 0, 0, 0, 0, 0);
    repeat (126) @(posedge clock);
    #1;
    check("ready_low_last_sweep", cfg_ready, 0);
    retire(32'd508, 32'd512, 0, 0, 0, 0, 0, 0);
    check("ready_after_sweep", cfg_ready, 1);
    idle(3);
    check("sweep_no_check_pass", pass_count, m_pass);

    cfg_write(1, 0, 5, 32'd9);
    for (int k = 0; k < 260; k++) begin
      expect_chk(3'b001);
      retire(32'h4, 32'h8, 0, 0, 0, 0, 0, 0);
    end
    idle(4);
    check("fail_saturated", fail_count, 8'hFF);
    check("pass_unchanged", pass_count, m_pass);

    retire(32'h4, 32'h8, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    m_pass = 0;
    m_fail = 0;
    idle(2);
    check("midreset_counts", {pass_count, fail_count}, 0);
    check("midreset_ff", first_fail_valid, 0);
    check("midreset_ready", cfg_ready, 0);
    @(negedge clock);
    rst_n = 1'b1;
    idle(5);

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
